// File: rtl/riscv_issue_pair_pkg.sv
// Shared types for the dual-issue instruction buffer: RV32 opcodes, ABI register names,
// queue entry layout and the canonical NOP encoding.
package riscv_issue_pair_pkg;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [4:0] {
    ABI_ZERO = 5'd0, ABI_RA, ABI_SP, ABI_GP, ABI_TP, ABI_T0, ABI_T1, ABI_T2,
    ABI_S0, ABI_S1, ABI_A0, ABI_A1, ABI_A2, ABI_A3, ABI_A4, ABI_A5,
    ABI_A6, ABI_A7, ABI_S2, ABI_S3, ABI_S4, ABI_S5, ABI_S6, ABI_S7,
    ABI_S8, ABI_S9, ABI_S10, ABI_S11, ABI_T3, ABI_T4, ABI_T5, ABI_T6
  } abi_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } issue_entry_t;

  localparam logic [31:0] ISSUE_NOP = 32'h0000_0013;

  // Branches and stores have no destination register; everything else may write rd.
  function automatic logic writes_rd(input opcode_t op);
    logic w;
    case (op)
      OPC_BRANCH, OPC_STORE: w = 1'b0;
      default:               w = 1'b1;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/riscv_issue_pair_if.sv
// Fetch/issue/decoder-side bundle of the issue buffer. master is the surrounding
// front/back-end, slave is the buffer itself.
interface riscv_issue_pair_if;
  logic [1:0]  fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_inst0;
  logic [31:0] fetch_inst1;
  logic        fetch_ready;
  logic        iss_stall;
  logic        iss0_valid;
  logic [31:0] iss0_pc;
  logic [31:0] iss0_inst;
  logic        iss1_valid;
  logic [31:0] iss1_pc;
  logic [31:0] iss1_inst;
  logic [31:0] p2_inst;
  logic        p2_noex;

  modport master (
    output fetch_valid, fetch_pc, fetch_inst0, fetch_inst1, iss_stall, p2_noex,
    input  fetch_ready, iss0_valid, iss0_pc, iss0_inst, iss1_valid, iss1_pc, iss1_inst,
           p2_inst
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_inst0, fetch_inst1, iss_stall, p2_noex,
    output fetch_ready, iss0_valid, iss0_pc, iss0_inst, iss1_valid, iss1_pc, iss1_inst,
           p2_inst
  );
endinterface

// File: rtl/riscv_issue_hazard.sv
// Intra-pair hazard check: slot1 may not issue alongside slot0 when slot0 is a
// control-flow/system op, or when slot1 touches slot0's destination register.
module riscv_issue_hazard
  import riscv_issue_pair_pkg::*;
(
  input  logic [31:0] slot0_inst,
  input  logic [31:0] slot1_inst,
  output logic        hz
);

  opcode_t  op0;
  abi_reg_t rd0;
  logic     ctrl_hz;
  logic     reg_hz;
  logic     unused_bits;

  assign op0 = opcode_t'(slot0_inst[6:0]);
  assign rd0 = abi_reg_t'(slot0_inst[11:7]);

  // Control-flow and system ops in slot0 always pin slot1.
  always_comb begin
    ctrl_hz = 1'b0;
    case (op0)
      OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM: ctrl_hz = 1'b1;
      default:                                   ctrl_hz = 1'b0;
    endcase
  end

  // Raw field compare: slot1's rd/rs1/rs2 positions against slot0's rd (covers RAW and WAW).
  always_comb begin
    reg_hz = 1'b0;
    if (writes_rd(op0) && (rd0 != ABI_ZERO)) begin
      reg_hz = (slot1_inst[19:15] == rd0) ||
               (slot1_inst[24:20] == rd0) ||
               (slot1_inst[11:7]  == rd0);
    end else begin
      reg_hz = 1'b0;
    end
  end

  assign hz = ctrl_hz | reg_hz;

  assign unused_bits = ^{slot0_inst[31:12], slot1_inst[31:25], slot1_inst[14:12],
                         slot1_inst[6:0]};

endmodule

// File: rtl/riscv_issue_pair.sv
// Dual-issue instruction buffer: circular queue of {pc, inst} between fetch and the two
// decode pipes, issuing the oldest entry to pipe 1 and the next one to pipe 2 when legal.
module riscv_issue_pair
  import riscv_issue_pair_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  riscv_issue_pair_if.slave    bus,
  output logic [31:0]          dual_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  issue_entry_t    mem_r [DEPTH];
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  logic [PW-1:0]   head_nx1_s;
  logic [PW-1:0]   tail_nx1_s;
  logic [CW-1:0]   free_s;
  logic [CW-1:0]   enq_n_s;
  logic [CW-1:0]   deq_n_s;
  logic            fetch_ready_s;
  logic            iss0_s;
  logic            iss1_s;
  logic            hz_s;
  issue_entry_t    slot0_s;
  issue_entry_t    slot1_s;

  assign head_nx1_s = head_r + PW'(1'b1);
  assign tail_nx1_s = tail_r + PW'(1'b1);
  assign slot0_s    = mem_r[head_r];
  assign slot1_s    = mem_r[head_nx1_s];

  // Two free slots are required even for a single-instruction fetch, so readiness only
  // depends on registered occupancy and never on this cycle's issue.
  assign free_s        = CW'(DEPTH) - count_r;
  assign fetch_ready_s = !flush && (free_s >= CW'(2'd2));

  // Number of entries written this cycle; the illegal 2'b10 pattern writes nothing.
  always_comb begin
    enq_n_s = '0;
    if (fetch_ready_s) begin
      case (bus.fetch_valid)
        2'b01:   enq_n_s = CW'(2'd1);
        2'b11:   enq_n_s = CW'(2'd2);
        default: enq_n_s = '0;
      endcase
    end else begin
      enq_n_s = '0;
    end
  end

  riscv_issue_hazard u_hazard (
    .slot0_inst (slot0_s.inst),
    .slot1_inst (slot1_s.inst),
    .hz         (hz_s)
  );

  assign iss0_s  = !flush && !bus.iss_stall && (count_r >= CW'(2'd1));
  assign iss1_s  = iss0_s && (count_r >= CW'(2'd2)) && !bus.p2_noex && !hz_s;
  assign deq_n_s = CW'(iss0_s) + CW'(iss1_s);

  assign bus.fetch_ready = fetch_ready_s;
  assign bus.iss0_valid  = iss0_s;
  assign bus.iss0_pc     = slot0_s.pc;
  assign bus.iss0_inst   = slot0_s.inst;
  assign bus.iss1_valid  = iss1_s;
  assign bus.iss1_pc     = slot1_s.pc;
  assign bus.iss1_inst   = slot1_s.inst;
  assign bus.p2_inst     = (count_r >= CW'(2'd2)) ? slot1_s.inst : ISSUE_NOP;

  // Queue storage: inst0 at tail, inst1 (pc+4) at tail+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (enq_n_s != '0) begin
        mem_r[tail_r] <= '{pc: bus.fetch_pc, inst: bus.fetch_inst0};
      end
      if (enq_n_s == CW'(2'd2)) begin
        mem_r[tail_nx1_s] <= '{pc: bus.fetch_pc + 32'd4, inst: bus.fetch_inst1};
      end
    end
  end

  // Pointers, occupancy and dual-issue counter; flush empties the queue in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      dual_cnt <= 32'd0;
    end else if (flush) begin
      head_r   <= tail_r;
      tail_r   <= tail_r;
      count_r  <= '0;
      dual_cnt <= dual_cnt;
    end else begin
      head_r   <= head_r + PW'(deq_n_s);
      tail_r   <= tail_r + PW'(enq_n_s);
      count_r  <= count_r + enq_n_s - deq_n_s;
      dual_cnt <= iss1_s ? (dual_cnt + 32'd1) : dual_cnt;
    end
  end

endmodule

// File: tb/tb_riscv_issue_pair.sv
// Bench for riscv_issue_pair: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic checked against a queue-based reference model.
module tb_riscv_issue_pair;
  import riscv_issue_pair_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
  localparam logic [31:0] ADDI_X2 = 32'h0020_0113;
  localparam logic [31:0] ADDI_X3 = 32'h0030_0193;
  localparam logic [31:0] ADDI_X4 = 32'h0040_0213;
  localparam logic [31:0] ADD_X3  = 32'h0010_81B3;
  localparam logic [31:0] LW_X5   = 32'h0001_2283;
  localparam logic [31:0] BEQ_12  = 32'h0020_8463;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] dual_cnt;

  riscv_issue_pair_if bus();

  riscv_issue_pair #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .dual_cnt (dual_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        fl;
    logic [1:0]  fv;
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic        st;
    logic        nx;
    logic        e_ready;
    logic        e_v0;
    logic        e_v1;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
    logic [31:0] e_p2;
    logic [31:0] e_dual;
  } vec_t;

  issue_entry_t mq[$];
  logic [31:0]  mdual;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [1:0] fv, input logic [31:0] pc,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic st, input logic nx);
    flush           = fl;
    bus.fetch_valid = fv;
    bus.fetch_pc    = pc;
    bus.fetch_inst0 = i0;
    bus.fetch_inst1 = i1;
    bus.iss_stall   = st;
    bus.p2_noex     = nx;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One hand-written cycle: drive at negedge, sample 1 time unit later.
  task automatic cyc(input logic fl, input logic [1:0] fv, input logic [31:0] pc,
                     input logic [31:0] i0, input logic [31:0] i1,
                     input logic st, input logic nx);
    @(negedge clk);
    drive(fl, fv, pc, i0, i1, st, nx);
    #1;
  endtask

  function automatic vec_t mk(input logic fl, input logic [1:0] fv, input logic [31:0] pc,
                              input logic [31:0] i0, input logic [31:0] i1,
                              input logic st, input logic nx,
                              input logic er, input logic e0, input logic e1,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic [31:0] du);
    vec_t v;
    v = '{fl, fv, pc, i0, i1, st, nx, er, e0, e1, p0, p1, p2, du};
    return v;
  endfunction

  // Pair rule from the architecture: control/system op in the older slot blocks pairing;
  // otherwise the younger may not name the older's destination in any register field.
  function automatic logic ref_pair_blocked(input logic [31:0] older, input logic [31:0] younger);
    logic [6:0] op;
    logic [4:0] dst;
    op = older[6:0];
    if (op inside {OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_SYSTEM}) return 1'b1;
    if (op == OPC_STORE) return 1'b0;
    dst = older[11:7];
    if (dst == 5'd0) return 1'b0;
    return (younger[19:15] == dst) || (younger[24:20] == dst) || (younger[11:7] == dst);
  endfunction

  function automatic logic [31:0] rnd_inst();
    opcode_t     ops[9] = '{OPC_OP_IMM, OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH,
                            OPC_JAL, OPC_JALR, OPC_SYSTEM, OPC_LUI};
    logic [31:0] w;
    w        = $urandom();
    w[6:0]   = ops[$urandom_range(8, 0)];
    w[11:7]  = 5'($urandom_range(3, 0));
    w[19:15] = 5'($urandom_range(3, 0));
    w[24:20] = 5'($urandom_range(3, 0));
    return w;
  endfunction

  vec_t vecs[21];

  initial begin
    logic        fl, st, nx, er, e0, e1;
    logic [1:0]  fv;
    logic [31:0] pc, i0, i1, ep2;

    rst = 1'b1;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    //      fl    fv     pc          i0       i1       st    nx    rdy   v0    v1    pc0         pc1         p2         dual
    vecs[0]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd0);
    vecs[1]  = mk(1'b0, 2'b11, 32'h100,   ADDI_X1, ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd0);
    vecs[2]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100,   32'h104,   ADDI_X2,   32'd0);
    vecs[3]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[4]  = mk(1'b0, 2'b11, 32'h200,   ADDI_X1, ADD_X3,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[5]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200,   32'h0,     ADD_X3,    32'd1);
    vecs[6]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204,   32'h0,     ISSUE_NOP, 32'd1);
    vecs[7]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[8]  = mk(1'b0, 2'b11, 32'h300,   ADDI_X1, LW_X5,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[9]  = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300,   32'h0,     LW_X5,     32'd1);
    vecs[10] = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h304,   32'h0,     ISSUE_NOP, 32'd1);
    vecs[11] = mk(1'b0, 2'b11, 32'h400,   BEQ_12,  ADDI_X4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[12] = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400,   32'h0,     ADDI_X4,   32'd1);
    vecs[13] = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h404,   32'h0,     ISSUE_NOP, 32'd1);
    vecs[14] = mk(1'b0, 2'b11, 32'h500,   ADDI_X2, ADDI_X4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[15] = mk(1'b0, 2'b01, 32'h508,   ADDI_X1, 32'h0,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ADDI_X4,   32'd1);
    vecs[16] = mk(1'b1, 2'b11, 32'h510,   ADDI_X3, ADDI_X4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,     32'h0,     ADDI_X4,   32'd1);
    vecs[17] = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[18] = mk(1'b0, 2'b11, 32'h600,   ADDI_X1, ADDI_X2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd1);
    vecs[19] = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h600,   32'h604,   ADDI_X2,   32'd1);
    vecs[20] = mk(1'b0, 2'b00, 32'h0,     32'h0,   32'h0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,     32'h0,     ISSUE_NOP, 32'd2);

    do_reset();

    for (int k = 0; k < 21; k++) begin
      cyc(vecs[k].fl, vecs[k].fv, vecs[k].pc, vecs[k].i0, vecs[k].i1, vecs[k].st, vecs[k].nx);
      chk($sformatf("vec%0d_ready", k), 32'(bus.fetch_ready), 32'(vecs[k].e_ready));
      chk($sformatf("vec%0d_v0", k),    32'(bus.iss0_valid),  32'(vecs[k].e_v0));
      chk($sformatf("vec%0d_v1", k),    32'(bus.iss1_valid),  32'(vecs[k].e_v1));
      if (vecs[k].e_v0) chk($sformatf("vec%0d_pc0", k), bus.iss0_pc, vecs[k].e_pc0);
      if (vecs[k].e_v1) chk($sformatf("vec%0d_pc1", k), bus.iss1_pc, vecs[k].e_pc1);
      chk($sformatf("vec%0d_p2", k),    bus.p2_inst, vecs[k].e_p2);
      chk($sformatf("vec%0d_dual", k),  dual_cnt,    vecs[k].e_dual);
    end

    // Fill to DEPTH under stall; pointers wrap since head sits at entry 1 here.
    cyc(1'b0, 2'b11, 32'h700, ADDI_X1, ADDI_X2, 1'b1, 1'b0);
    chk("fill_a_ready", 32'(bus.fetch_ready), 32'd1);
    cyc(1'b0, 2'b11, 32'h708, ADDI_X3, ADDI_X4, 1'b1, 1'b0);
    chk("fill_b_ready", 32'(bus.fetch_ready), 32'd1);
    chk("fill_b_v0",    32'(bus.iss0_valid),  32'd0);
    cyc(1'b0, 2'b11, 32'h710, LW_X5, LW_X5, 1'b1, 1'b0);
    chk("full_ready", 32'(bus.fetch_ready), 32'd0);
    chk("full_p2",    bus.p2_inst, ADDI_X2);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drain1_v0",   32'(bus.iss0_valid), 32'd1);
    chk("drain1_pc0",  bus.iss0_pc,   32'h700);
    chk("drain1_i0",   bus.iss0_inst, ADDI_X1);
    chk("drain1_v1",   32'(bus.iss1_valid), 32'd1);
    chk("drain1_pc1",  bus.iss1_pc,   32'h704);
    chk("drain1_rdy",  32'(bus.fetch_ready), 32'd0);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drain2_pc0",  bus.iss0_pc,   32'h708);
    chk("drain2_i0",   bus.iss0_inst, ADDI_X3);
    chk("drain2_v1",   32'(bus.iss1_valid), 32'd1);
    chk("drain2_pc1",  bus.iss1_pc,   32'h70c);
    chk("drain2_i1",   bus.iss1_inst, ADDI_X4);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("drain3_v0",   32'(bus.iss0_valid), 32'd0);
    chk("drain3_dual", dual_cnt, 32'd4);

    // Three entries must already block fetch; flush then empties the queue.
    cyc(1'b0, 2'b11, 32'h800, ADDI_X1, ADDI_X2, 1'b1, 1'b0);
    cyc(1'b0, 2'b01, 32'h808, ADDI_X3, 32'h0,   1'b1, 1'b0);
    chk("c3_pre_ready", 32'(bus.fetch_ready), 32'd1);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("c3_ready", 32'(bus.fetch_ready), 32'd0);
    cyc(1'b1, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("c3_flush_v0", 32'(bus.iss0_valid), 32'd0);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("c3_post_ready", 32'(bus.fetch_ready), 32'd1);
    chk("c3_post_v0",    32'(bus.iss0_valid),  32'd0);

    // Illegal fetch_valid 2'b10 enqueues nothing.
    cyc(1'b0, 2'b10, 32'h900, ADDI_X1, ADDI_X2, 1'b0, 1'b0);
    cyc(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("ill10_v0", 32'(bus.iss0_valid), 32'd0);

    // Reset mid-operation discards contents and clears the counter.
    cyc(1'b0, 2'b11, 32'hA00, ADDI_X1, ADDI_X2, 1'b1, 1'b0);
    do_reset();
    #1;
    chk("rst_dual",  dual_cnt, 32'd0);
    chk("rst_v0",    32'(bus.iss0_valid),  32'd0);
    chk("rst_ready", 32'(bus.fetch_ready), 32'd1);
    chk("rst_p2",    bus.p2_inst, ISSUE_NOP);

    // Randomized traffic against the queue model (model empty after reset).
    mq.delete();
    mdual = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      fl = ($urandom_range(15, 0) == 0);
      st = ($urandom_range(3, 0) == 0);
      nx = ($urandom_range(3, 0) == 0);
      fv = 2'($urandom_range(3, 0));
      pc = $urandom() & 32'hFFFF_FFFC;
      i0 = rnd_inst();
      i1 = rnd_inst();
      cyc(fl, fv, pc, i0, i1, st, nx);

      er  = !fl && ((DEPTH - mq.size()) >= 2);
      e0  = !fl && !st && (mq.size() >= 1);
      e1  = e0 && (mq.size() >= 2) && !nx && !ref_pair_blocked(mq[0].inst, mq[1].inst);
      ep2 = (mq.size() >= 2) ? mq[1].inst : ISSUE_NOP;

      chk("rnd_ready", 32'(bus.fetch_ready), 32'(er));
      chk("rnd_v0",    32'(bus.iss0_valid),  32'(e0));
      chk("rnd_v1",    32'(bus.iss1_valid),  32'(e1));
      if (e0) begin
        chk("rnd_pc0", bus.iss0_pc,   mq[0].pc);
        chk("rnd_i0",  bus.iss0_inst, mq[0].inst);
      end
      if (e1) begin
        chk("rnd_pc1", bus.iss1_pc,   mq[1].pc);
        chk("rnd_i1",  bus.iss1_inst, mq[1].inst);
      end
      chk("rnd_p2",   bus.p2_inst, ep2);
      chk("rnd_dual", dual_cnt,    mdual);

      if (fl) begin
        mq.delete();
      end else begin
        if (e0) void'(mq.pop_front());
        if (e1) void'(mq.pop_front());
        if (er && (fv == 2'b01 || fv == 2'b11)) mq.push_back('{pc: pc, inst: i0});
        if (er && fv == 2'b11) mq.push_back('{pc: pc + 32'd4, inst: i1});
      end
      if (e1) mdual = mdual + 32'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
